// File: rtl/ghost_motion_unit.sv
// Ghost motion unit: takes the requested dx/dy codes on a move tick, probes the two
// leading-edge corner tiles of the candidate step through a synchronous map read port,
// and commits at most one single-pixel step per tick. Also flags sprite overlap with Pac-Man.
module ghost_motion_unit #(
  parameter logic [8:0]  START_X    = 9'd80,
  parameter logic [8:0]  START_Y    = 9'd80,
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned SPRITE     = 8,
  parameter int unsigned MAP_W      = 21,
  parameter int unsigned MAP_H      = 21,
  parameter int unsigned X_FIRST    = 1
) (
  input  logic       clock_in,
  input  logic       rst,
  input  logic       move_tick,
  input  logic [1:0] dx,
  input  logic [1:0] dy,
  input  logic [8:0] pacman_x,
  input  logic [8:0] pacman_y,
  output logic       map_rd,
  output logic [4:0] map_tile_x,
  output logic [4:0] map_tile_y,
  input  logic       map_wall,
  output logic [8:0] ghost_x,
  output logic [8:0] ghost_y,
  output logic       busy,
  output logic       moved,
  output logic       stalled,
  output logic       tick_drop,
  output logic       caught
);

  // Largest legal top-left coordinate: sprite must stay fully inside the map.
  localparam logic [8:0] XMAX = 9'((MAP_W << TILE_SHIFT) - SPRITE);
  localparam logic [8:0] YMAX = 9'((MAP_H << TILE_SHIFT) - SPRITE);
  localparam logic [8:0] SPR  = 9'(SPRITE);
  localparam bit         XF   = (X_FIRST != 0);

  typedef enum logic [1:0] {StIdle, StChk1, StChk2, StEval} state_e;

  state_e     state_q, state_d;
  logic [1:0] dx_q, dx_d, dy_q, dy_d;
  logic       axis_y_q, axis_y_d;   // axis under test: 0 = x, 1 = y
  logic       alt_q, alt_d;         // other axis still eligible and untried
  logic       wall_a_q, wall_a_d;
  logic [8:0] gx_q, gx_d, gy_q, gy_d;
  logic       moved_q, moved_d, stalled_q, stalled_d, drop_q, drop_d, caught_q, caught_d;

  logic       neg;
  logic [8:0] lead_px, side_a_px, side_b_px, side_px;
  logic [4:0] lead_tile, side_tile;
  logic       x_ok, y_ok, first_ok, second_ok;
  logic [8:0] dist_x, dist_y;

  // A step is possible only for a real direction code that keeps the sprite in bounds.
  function automatic logic step_ok(input logic [1:0] code, input logic [8:0] pos,
                                   input logic [8:0] lim);
    logic ok;
    case (code)
      2'b01:   ok = (pos < lim);
      2'b10:   ok = (pos != 9'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Leading-edge corner pixels of the candidate position for the axis under test.
  always_comb begin
    neg = axis_y_q ? (dy_q == 2'b10) : (dx_q == 2'b10);
    if (axis_y_q) begin
      lead_px   = neg ? gy_q - 9'd1 : gy_q + SPR;
      side_a_px = gx_q;
      side_b_px = gx_q + SPR - 9'd1;
    end else begin
      lead_px   = neg ? gx_q - 9'd1 : gx_q + SPR;
      side_a_px = gy_q;
      side_b_px = gy_q + SPR - 9'd1;
    end
    side_px   = (state_q == StChk2) ? side_b_px : side_a_px;
    lead_tile = 5'(lead_px >> TILE_SHIFT);
    side_tile = 5'(side_px >> TILE_SHIFT);
  end

  // Map read port: corner A in CHK1, corner B in CHK2, idle-zero otherwise.
  always_comb begin
    map_rd     = (state_q == StChk1) || (state_q == StChk2);
    map_tile_x = '0;
    map_tile_y = '0;
    if (map_rd) begin
      map_tile_x = axis_y_q ? side_tile : lead_tile;
      map_tile_y = axis_y_q ? lead_tile : side_tile;
    end
  end

  // Next-state, step commit and pulse generation.
  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    axis_y_d  = axis_y_q;
    alt_d     = alt_q;
    wall_a_d  = wall_a_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    moved_d   = 1'b0;
    stalled_d = 1'b0;
    drop_d    = move_tick && (state_q != StIdle);

    x_ok      = step_ok(dx, gx_q, XMAX);
    y_ok      = step_ok(dy, gy_q, YMAX);
    first_ok  = XF ? x_ok : y_ok;
    second_ok = XF ? y_ok : x_ok;

    dist_x    = (gx_q >= pacman_x) ? gx_q - pacman_x : pacman_x - gx_q;
    dist_y    = (gy_q >= pacman_y) ? gy_q - pacman_y : pacman_y - gy_q;
    caught_d  = (dist_x < SPR) && (dist_y < SPR);

    unique case (state_q)
      StIdle: begin
        if (move_tick) begin
          dx_d = dx;
          dy_d = dy;
          if (first_ok) begin
            axis_y_d = ~XF;
            alt_d    = second_ok;
            state_d  = StChk1;
          end else if (second_ok) begin
            axis_y_d = XF;
            alt_d    = 1'b0;
            state_d  = StChk1;
          end else begin
            stalled_d = 1'b1;
          end
        end
      end
      StChk1: state_d = StChk2;
      StChk2: begin
        wall_a_d = map_wall;
        state_d  = StEval;
      end
      StEval: begin
        if (!wall_a_q && !map_wall) begin
          if (axis_y_q) gy_d = neg ? gy_q - 9'd1 : gy_q + 9'd1;
          else          gx_d = neg ? gx_q - 9'd1 : gx_q + 9'd1;
          moved_d = 1'b1;
          state_d = StIdle;
        end else if (alt_q) begin
          axis_y_d = ~axis_y_q;
          alt_d    = 1'b0;
          state_d  = StChk1;
        end else begin
          stalled_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any evaluation without committing.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      state_q   <= StIdle;
      dx_q      <= '0;
      dy_q      <= '0;
      axis_y_q  <= 1'b0;
      alt_q     <= 1'b0;
      wall_a_q  <= 1'b0;
      gx_q      <= START_X;
      gy_q      <= START_Y;
      moved_q   <= 1'b0;
      stalled_q <= 1'b0;
      drop_q    <= 1'b0;
      caught_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      axis_y_q  <= axis_y_d;
      alt_q     <= alt_d;
      wall_a_q  <= wall_a_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      moved_q   <= moved_d;
      stalled_q <= stalled_d;
      drop_q    <= drop_d;
      caught_q  <= caught_d;
    end
  end

  assign ghost_x   = gx_q;
  assign ghost_y   = gy_q;
  assign busy      = (state_q != StIdle);
  assign moved     = moved_q;
  assign stalled   = stalled_q;
  assign tick_drop = drop_q;
  assign caught    = caught_q;

endmodule

// File: tb/tb_ghost_motion_unit.sv
// Bench for ghost_motion_unit: a tick-level model predicts each tick's outcome and timing
// from the wall map, and a compare process checks every output on every cycle.
module tb_ghost_motion_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_tick = 1'b0;
  logic [1:0] dx = 2'b00, dy = 2'b00;
  logic [8:0] pacman_x = 9'd300, pacman_y = 9'd300;
  logic       map_rd;
  logic [4:0] map_tile_x, map_tile_y;
  logic       map_wall = 1'b0;
  logic [8:0] ghost_x, ghost_y;
  logic       busy, moved, stalled, tick_drop, caught;

  bit walls [0:31][0:31];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_motion_unit dut (
    .clock_in  (clk),
    .rst       (rst),
    .move_tick (move_tick),
    .dx        (dx),
    .dy        (dy),
    .pacman_x  (pacman_x),
    .pacman_y  (pacman_y),
    .map_rd    (map_rd),
    .map_tile_x(map_tile_x),
    .map_tile_y(map_tile_y),
    .map_wall  (map_wall),
    .ghost_x   (ghost_x),
    .ghost_y   (ghost_y),
    .busy      (busy),
    .moved     (moved),
    .stalled   (stalled),
    .tick_drop (tick_drop),
    .caught    (caught)
  );

  // Synchronous map ROM: wall bit one cycle after the read strobe.
  always @(posedge clk) if (map_rd) map_wall <= walls[map_tile_y][map_tile_x];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int mx = 80, my = 80;
  int rem = 0, total = 0, nx = 0, ny = 0;
  bit pend_move = 0, started = 0;
  bit e_moved = 0, e_stalled = 0, e_drop = 0, e_caught = 0;
  int ptx [4];
  int pty [4];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit elig(input logic [1:0] c, input int p);
    return (c == 2'b01 && p < 160) || (c == 2'b10 && p > 0);
  endfunction

  // Decide the whole tick at once: try eligible axes x then y, first clear one wins.
  task automatic plan(input logic [1:0] cx, input logic [1:0] cy);
    int axes[$];
    int tried, s, lead;
    bit found;
    tried = 0;
    found = 0;
    if (elig(cx, mx)) axes.push_back(0);
    if (elig(cy, my)) axes.push_back(1);
    foreach (axes[k]) begin
      if (!found) begin
        s = (((axes[k] == 0) ? cx : cy) == 2'b01) ? 1 : -1;
        if (axes[k] == 0) begin
          lead = (s > 0) ? mx + 8 : mx - 1;
          ptx[2*k] = lead / 8;  ptx[2*k+1] = lead / 8;
          pty[2*k] = my / 8;    pty[2*k+1] = (my + 7) / 8;
        end else begin
          lead = (s > 0) ? my + 8 : my - 1;
          pty[2*k] = lead / 8;  pty[2*k+1] = lead / 8;
          ptx[2*k] = mx / 8;    ptx[2*k+1] = (mx + 7) / 8;
        end
        tried++;
        if (!walls[pty[2*k]][ptx[2*k]] && !walls[pty[2*k+1]][ptx[2*k+1]]) begin
          found = 1;
          nx = mx + ((axes[k] == 0) ? s : 0);
          ny = my + ((axes[k] == 1) ? s : 0);
        end
      end
    end
    pend_move = found;
    total     = 3 * tried;
    rem       = total;
    if (tried == 0) e_stalled = 1;
  endtask

  initial forever begin
    @(posedge clk);
    started = 1;
    if (rst) begin
      mx = 80; my = 80; rem = 0; total = 0;
      e_moved = 0; e_stalled = 0; e_drop = 0; e_caught = 0;
    end else begin
      e_caught  = (iabs(mx - int'(pacman_x)) < 8) && (iabs(my - int'(pacman_y)) < 8);
      e_moved   = 0;
      e_stalled = 0;
      e_drop    = 0;
      if (rem > 0) begin
        e_drop = move_tick;
        rem--;
        if (rem == 0) begin
          if (pend_move) begin
            mx = nx; my = ny; e_moved = 1;
          end else begin
            e_stalled = 1;
          end
        end
      end else if (move_tick) begin
        plan(dx, dy);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (started) begin
      int el, idx;
      bit rd;
      el = total - rem;
      rd = (rem > 0) && (el % 3 != 2);
      chk("ghost_x", 32'(ghost_x), 32'(mx));
      chk("ghost_y", 32'(ghost_y), 32'(my));
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("moved", 32'(moved), 32'(e_moved));
      chk("stalled", 32'(stalled), 32'(e_stalled));
      chk("tick_drop", 32'(tick_drop), 32'(e_drop));
      chk("caught", 32'(caught), 32'(e_caught));
      chk("map_rd", 32'(map_rd), 32'(rd));
      if (rd) begin
        idx = (el / 3) * 2 + (el % 3);
        chk("map_tile_x", 32'(map_tile_x), 32'(ptx[idx]));
        chk("map_tile_y", 32'(map_tile_y), 32'(pty[idx]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick in cycle T; returns 1 time unit into cycle T+1.
  task automatic tick(input logic [1:0] x, input logic [1:0] y);
    @(posedge clk); #1;
    dx = x; dy = y; move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a tick presented: must have no effect.
    rst = 1'b1; move_tick = 1'b1; dx = 2'b01;
    step_n(2);
    rst = 1'b0; move_tick = 1'b0; dx = 2'b00;
    step_n(2);
    chk("lit_reset_x", 32'(ghost_x), 32'd80);
    chk("lit_reset_y", 32'(ghost_y), 32'd80);
    chk("lit_reset_moved", 32'(moved), 32'd0);
    chk("lit_reset_rd", 32'(map_rd), 32'd0);

    // Open map, +x step.
    tick(2'b01, 2'b00);
    chk("lit_rd_t1", 32'(map_rd), 32'd1);
    chk("lit_tile_x_t1", 32'(map_tile_x), 32'd11);
    chk("lit_tile_y_t1", 32'(map_tile_y), 32'd10);
    step_n(1);
    chk("lit_rd_t2", 32'(map_rd), 32'd1);
    step_n(2);
    chk("lit_x_t4", 32'(ghost_x), 32'd81);
    chk("lit_moved_t4", 32'(moved), 32'd1);
    chk("lit_busy_t4", 32'(busy), 32'd0);
    step_n(2);

    // Wall to the right: x blocked, y (-1) taken.
    walls[10][11] = 1;
    tick(2'b01, 2'b10);
    step_n(3);
    chk("lit_busy_t4_second", 32'(busy), 32'd1);
    step_n(3);
    chk("lit_y_t7", 32'(ghost_y), 32'd79);
    chk("lit_x_t7", 32'(ghost_x), 32'd81);
    chk("lit_moved_t7", 32'(moved), 32'd1);
    step_n(2);

    // Both axes walled.
    walls[9][10] = 1;
    tick(2'b01, 2'b10);
    step_n(6);
    chk("lit_stall_t7", 32'(stalled), 32'd1);
    chk("lit_stall_x", 32'(ghost_x), 32'd81);
    chk("lit_stall_y", 32'(ghost_y), 32'd79);
    step_n(2);
    walls[9][10] = 0;
    walls[10][11] = 0;

    // No direction at all.
    tick(2'b11, 2'b00);
    chk("lit_nodir_stall", 32'(stalled), 32'd1);
    chk("lit_nodir_rd", 32'(map_rd), 32'd0);
    step_n(2);

    // Walk to the right edge, then try to step past it.
    for (int i = 0; i < 79; i++) begin
      tick(2'b01, 2'b00);
      step_n(4);
    end
    chk("lit_at_xmax", 32'(ghost_x), 32'd160);
    tick(2'b01, 2'b00);
    chk("lit_xmax_stall", 32'(stalled), 32'd1);
    chk("lit_xmax_rd", 32'(map_rd), 32'd0);
    step_n(2);

    // Walk to the left edge, then try to step past it.
    for (int i = 0; i < 160; i++) begin
      tick(2'b10, 2'b00);
      step_n(4);
    end
    chk("lit_at_x0", 32'(ghost_x), 32'd0);
    tick(2'b10, 2'b00);
    chk("lit_x0_stall", 32'(stalled), 32'd1);
    chk("lit_x0_rd", 32'(map_rd), 32'd0);
    step_n(2);

    // Second tick while busy is dropped; latched direction keeps +x.
    tick(2'b01, 2'b00);
    step_n(1);
    dx = 2'b10; move_tick = 1'b1;
    step_n(1);
    move_tick = 1'b0;
    chk("lit_drop_t3", 32'(tick_drop), 32'd1);
    step_n(1);
    chk("lit_drop_x_t4", 32'(ghost_x), 32'd1);
    step_n(6);
    chk("lit_drop_one_step", 32'(ghost_x), 32'd1);

    // Reset mid-evaluation.
    tick(2'b01, 2'b00);
    step_n(1);
    rst = 1'b1;
    step_n(1);
    rst = 1'b0;
    chk("lit_rst_mid_x", 32'(ghost_x), 32'd80);
    chk("lit_rst_mid_y", 32'(ghost_y), 32'd80);
    chk("lit_rst_mid_busy", 32'(busy), 32'd0);
    step_n(4);

    // Sprite overlap edges.
    pacman_x = 9'd87; pacman_y = 9'd80;
    step_n(2);
    chk("lit_caught_87", 32'(caught), 32'd1);
    pacman_x = 9'd88;
    step_n(2);
    chk("lit_caught_88", 32'(caught), 32'd0);
    pacman_x = 9'd73;
    step_n(2);
    chk("lit_caught_73", 32'(caught), 32'd1);
    pacman_x = 9'd80; pacman_y = 9'd72;
    step_n(2);
    chk("lit_caught_y72", 32'(caught), 32'd0);
    pacman_x = 9'd300; pacman_y = 9'd300;
    step_n(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_motion_unit.md
Name: ghost_motion_unit

Overview:
- Downstream of the ghost direction stages.
- Consumes a ghost's requested dx/dy codes, checks the candidate step against the wall map through a synchronous map-ROM read port, and commits at most one pixel step per move tick.
- Holds the authoritative ghost position, which it feeds back to the direction stage and the renderer.
- Flags Pac-Man contact.

Parameters:
- START_X, 9'd80, spawn x in pixels; value after reset.
- START_Y, 9'd80, spawn y in pixels; value after reset.
- TILE_SHIFT, 3, log2 of tile size in pixels (8 px tiles).
- SPRITE, 8, ghost and Pac-Man sprite edge in pixels.
- MAP_W, 21, map width in tiles.
- MAP_H, 21, map height in tiles.
- X_FIRST, 1, 1 = try x axis before y; 0 = y before x.

Ports:
- clock_in  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- move_tick  in  1  single-cycle step strobe.
- dx  in  2  x direction code: 01 = +1, 10 = -1, 00 or 11 = none.
- dy  in  2  y direction code, same encoding as dx.
- pacman_x  in  9  Pac-Man x in pixels.
- pacman_y  in  9  Pac-Man y in pixels.
- map_rd  out  1  map read strobe.
- map_tile_x  out  5  tile column queried.
- map_tile_y  out  5  tile row queried.
- map_wall  in  1  wall bit; valid exactly one cycle after map_rd.
- ghost_x  out  9  current ghost x.
- ghost_y  out  9  current ghost y.
- busy  out  1  step evaluation in progress.
- moved  out  1  one-cycle pulse when a step commits.
- stalled  out  1  one-cycle pulse when a tick ends with no move.
- tick_drop  out  1  one-cycle pulse when move_tick arrives while busy.
- caught  out  1  registered sprite overlap with Pac-Man.

Behaviour:
- Reset values: ghost_x = START_X, ghost_y = START_Y. busy, moved, stalled, tick_drop, caught, map_rd = 0. map_tile_x/y = 0. FSM = IDLE.
- rst in any state aborts evaluation. No partial commit.
- FSM states: IDLE, CHK1, CHK2, EVAL.
- In IDLE, move_tick latches dx/dy, orders the two axes per X_FIRST, and selects the first eligible axis.
  - An axis is eligible when its code is 01/10 and the candidate stays inside [0, XMAX] / [0, YMAX], where XMAX = MAP_W*2^TILE_SHIFT - SPRITE (160) and YMAX likewise.
  - A -1 step from 0 is ineligible (no wrap). A +1 step at max is ineligible.
  - No eligible axis: stalled pulses the next cycle, no map access, stay IDLE.
- CHK1: map_rd = 1 with corner A tile. CHK2: map_rd = 1 with corner B tile; sample corner A wall. EVAL: sample corner B wall.
- Corner tiles are pixel >> TILE_SHIFT of the leading edge of the candidate position.
  - +x: column x+SPRITE; rows y and y+SPRITE-1.
  - -x: column x-1; same rows.
  - y axis symmetric.
- EVAL, both corners clear: commit the ±1 step on that axis, moved = 1 next cycle, return to IDLE.
- EVAL, either corner a wall: if the other axis is eligible and not yet tried, go to CHK1 for it. Otherwise stalled = 1 next cycle, IDLE.
- Latency: tick in cycle T, first-axis success → new position and moved visible in T+4. Second-axis success → T+7.
- busy = 1 from T+1 until the cycle position and moved update. It is 0 whenever the FSM is IDLE.
- move_tick while busy: ignored, tick_drop pulses the next cycle, latched directions unchanged.
- At most one axis moves per tick. Never diagonal.
- caught updates every cycle: 1 iff |ghost_x-pacman_x| < SPRITE and |ghost_y-pacman_y| < SPRITE, using unsigned magnitude of the 9-bit difference.

Test Plan:
- rst held 2 cycles → ghost (80,80), all pulses 0, map_rd 0; dx=01 tick during rst has no effect.
- Open map, dx=01 dy=00, tick at T → map_rd at T+1/T+2, ghost_x=81 and moved=1 at T+4, busy 0 at T+4.
- Wall at tile right of ghost, dx=01 dy=10, X_FIRST=1 → x blocked, y tried; ghost_y=79 at T+7, ghost_x unchanged.
- Both axes walled → stalled pulse at T+7, position unchanged. dx=11 dy=00 → stalled at T+1, no map_rd.
- ghost_x=0, dx=10, dy=00 → no map access, stalled, ghost_x stays 0. ghost_x=160, dx=01 → same.
- Tick at T and T+2 → tick_drop pulse at T+3, one step only. rst at T+2 → (80,80), no moved pulse.
- Pac-Man at (87,80) with ghost at (80,80) → caught=1; at (88,80) → caught=0.
